// File: rtl/dcache_victim_wb_buffer.sv
// Victim write-back FIFO between the data cache and block RAM, with refill forwarding.
// Optional DCACHE_WB_COALESCE_EN merges a victim into a queued entry with the same line address.
module dcache_victim_wb_buffer #(
    parameter int LINE_BITS  = 128,
    parameter int LADDR_BITS = 10,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  evict_valid,
    output logic                  evict_ready,
    input  logic [LADDR_BITS-1:0] evict_addr,
    input  logic [LINE_BITS-1:0]  evict_data,
    input  logic [LADDR_BITS-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [LINE_BITS-1:0]  lookup_data,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [LADDR_BITS-1:0] mem_wr_addr,
    output logic [LINE_BITS-1:0]  mem_wr_data,
    output logic [CW-1:0]         count,
    output logic                  empty
);

    logic [LADDR_BITS-1:0] addr_q [DEPTH];
    logic [LINE_BITS-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;

    logic full;
    logic pop;
    logic push;
    logic alloc;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign mem_wr_valid = !empty;
    assign mem_wr_addr  = addr_q[rd_ptr];
    assign mem_wr_data  = data_q[rd_ptr];
    assign pop          = mem_wr_valid && mem_wr_ready;
    assign push         = evict_valid && evict_ready;

`ifdef DCACHE_WB_COALESCE_EN
    logic          co_hit;
    logic [PW-1:0] co_idx;

    // The head being drained this cycle cannot absorb a merge.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == evict_addr &&
                !(pop && PW'(i) == rd_ptr)) begin
                co_hit = 1'b1;
                co_idx = PW'(i);
            end
        end
    end

    assign evict_ready = !full || co_hit;
    assign alloc       = push && !co_hit;
`else
    assign evict_ready = !full;
    assign alloc       = push;
`endif

    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid_q[idx] && addr_q[idx] == lookup_addr) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (alloc) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(alloc) - CW'(pop);
        end
    end

    // Payload arrays need no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[wr_ptr] <= evict_addr;
            data_q[wr_ptr] <= evict_data;
        end
`ifdef DCACHE_WB_COALESCE_EN
        else if (push) begin
            data_q[co_idx] <= evict_data;
        end
`endif
    end

endmodule

// File: tb/tb_dcache_victim_wb_buffer.sv
// Directed bench for dcache_victim_wb_buffer.
module tb_dcache_victim_wb_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         evict_valid = 1'b0;
    logic         evict_ready;
    logic [9:0]   evict_addr = '0;
    logic [127:0] evict_data = '0;
    logic [9:0]   lookup_addr = '0;
    logic         lookup_hit;
    logic [127:0] lookup_data;
    logic         mem_wr_valid;
    logic         mem_wr_ready = 1'b0;
    logic [9:0]   mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic [2:0]   count;
    logic         empty;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] DATA_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DATA_B = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;

    dcache_victim_wb_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_addr(evict_addr), .evict_data(evict_data),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mkdata(input logic [9:0] a);
        return {4{22'h2a5a5, a}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] a, input logic [127:0] d);
        evict_valid = 1'b1;
        evict_addr  = a;
        evict_data  = d;
        step();
        evict_valid = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_empty", 128'(empty), 128'd1);
        chk("rst_ready", 128'(evict_ready), 128'd1);
        chk("rst_mwv", 128'(mem_wr_valid), 128'd0);
        chk("rst_hit", 128'(lookup_hit), 128'd0);
        rst_n = 1'b1;
        step();

        // pushed entry is not visible in its push cycle
        evict_valid = 1'b1;
        evict_addr  = 10'h040;
        evict_data  = DATA_A;
        lookup_addr = 10'h040;
        #1;
        chk("push_same_cyc_hit", 128'(lookup_hit), 128'd0);
        evict_valid = 1'b0;
        #1;

        // fill to full, RAM busy
        for (int i = 0; i < 4; i++) push(10'h010 + 10'(i), mkdata(10'h010 + 10'(i)));
        chk("full_count", 128'(count), 128'd4);
        chk("full_ready", 128'(evict_ready), 128'd0);
        chk("full_head", 128'(mem_wr_addr), 128'h010);
        lookup_addr = 10'h012;
        #1;
        chk("fwd_hit", 128'(lookup_hit), 128'd1);
        chk("fwd_data", lookup_data, mkdata(10'h012));

        // fifth push held off
        evict_valid = 1'b1;
        evict_addr  = 10'h014;
        evict_data  = mkdata(10'h014);
        step();
        chk("hold_count", 128'(count), 128'd4);
        evict_valid = 1'b0;

        // drain in order; popping head still forwards
        mem_wr_ready = 1'b1;
        lookup_addr  = 10'h010;
        #1;
        chk("pop_fwd_hit", 128'(lookup_hit), 128'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", 128'(mem_wr_addr), 128'(10'h010 + 10'(i)));
            chk("drain_data", mem_wr_data, mkdata(10'h010 + 10'(i)));
            step();
        end
        chk("drain_empty", 128'(empty), 128'd1);
        chk("drain_mwv", 128'(mem_wr_valid), 128'd0);
        mem_wr_ready = 1'b0;

        // full + simultaneous pop: push rejected
        for (int i = 0; i < 4; i++) push(10'h030 + 10'(i), mkdata(10'h030 + 10'(i)));
        evict_valid  = 1'b1;
        evict_addr   = 10'h034;
        evict_data   = mkdata(10'h034);
        mem_wr_ready = 1'b1;
        #1;
        chk("pp_ready", 128'(evict_ready), 128'd0);
        step();
        chk("pp_count", 128'(count), 128'd3);
        chk("pp_ready2", 128'(evict_ready), 128'd1);
        mem_wr_ready = 1'b0;
        step();
        evict_valid = 1'b0;
        chk("pp_count2", 128'(count), 128'd4);
        mem_wr_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("pp_drain", 128'(mem_wr_addr), 128'(10'h030 + 10'(i)));
            step();
        end
        chk("pp_empty", 128'(empty), 128'd1);
        mem_wr_ready = 1'b0;

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) push(10'h050 + 10'(i), mkdata(10'h050));
        chk("pre_rst_count", 128'(count), 128'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 128'(count), 128'd0);
        chk("arst_empty", 128'(empty), 128'd1);
        chk("arst_mwv", 128'(mem_wr_valid), 128'd0);
        chk("arst_ready", 128'(evict_ready), 128'd1);
        step();
        rst_n = 1'b1;
        step();

        // duplicate address
        push(10'h020, DATA_A);
        push(10'h020, DATA_B);
        lookup_addr = 10'h020;
        #1;
        chk("dup_hit", 128'(lookup_hit), 128'd1);
        chk("dup_data", lookup_data, DATA_B);
        lookup_addr = 10'h021;
        #1;
        chk("miss_hit", 128'(lookup_hit), 128'd0);
        chk("miss_data", lookup_data, 128'd0);
        mem_wr_ready = 1'b1;
`ifdef DCACHE_WB_COALESCE_EN
        chk("co_count", 128'(count), 128'd1);
        chk("co_data", mem_wr_data, DATA_B);
        step();
`else
        chk("dup_count", 128'(count), 128'd2);
        chk("dup_ram1", mem_wr_data, DATA_A);
        step();
        chk("dup_ram2", mem_wr_data, DATA_B);
        step();
`endif
        chk("dup_empty", 128'(empty), 128'd1);
        mem_wr_ready = 1'b0;

        // sustained push+pop with wrapping pointers
        push(10'h100, mkdata(10'h100));
        push(10'h101, mkdata(10'h101));
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            evict_valid = 1'b1;
            evict_addr  = 10'h102 + 10'(i);
            evict_data  = mkdata(10'h102 + 10'(i));
            #1;
            chk("ss_addr", 128'(mem_wr_addr), 128'(10'h100 + 10'(i)));
            chk("ss_data", mem_wr_data, mkdata(10'h100 + 10'(i)));
            step();
            chk("ss_count", 128'(count), 128'd2);
        end
        evict_valid = 1'b0;
        chk("ss_tail0", 128'(mem_wr_addr), 128'h140);
        step();
        chk("ss_tail1", 128'(mem_wr_addr), 128'h141);
        step();
        chk("ss_empty", 128'(empty), 128'd1);
        mem_wr_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
